apb4_mem_slave: RTL and testbench

APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

---
 rtl/apb4_mem_slave.sv | 119 +++++++++++
 tb/tb_apb4_mem_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb4_mem_slave.sv
// APB4 completer backed by a byte-strobed word memory, with a configurable number of
// wait states and an independent synchronous local read port (port B).
module apb4_mem_slave #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDR_WIDTH-1:0]    PADDR,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [DATA_WIDTH/8-1:0]  PSTRB,
  input  logic [2:0]               PPROT,
  output logic                     PREADY,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PSLVERR,
  input  logic                     b_en,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  output logic [DATA_WIDTH-1:0]    b_rdata
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  state_t                state, next_state;
  logic [3:0]            cnt, next_cnt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [AW-1:0]         idx;
  logic                  err, do_write;
  logic                  ready_d, slverr_d;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  unused_prot;

  // Protection attributes are accepted but never used for filtering.
  assign unused_prot = ^PPROT;

  assign word_idx = PADDR >> OFFW;
  assign idx      = word_idx[AW-1:0];
  assign err      = (word_idx >= ADDR_WIDTH'(DEPTH))
                 || ((PADDR & ADDR_WIDTH'(BYTES - 1)) != '0)
                 || (!PWRITE && (PSTRB != '0));

  // A write commits on the edge that ends DONE, and only if the master kept the transfer alive.
  assign do_write = (state == DONE) && PSEL && PENABLE && PWRITE && !err && !PRESET;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          if (WAIT_STATES == 0) begin
            next_state = DONE;
          end else begin
            next_cnt   = 4'(WAIT_STATES);
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (!PSEL) begin
          next_cnt   = '0;
          next_state = IDLE;
        end else begin
          next_cnt = cnt - 4'd1;
          if (cnt == 4'd1) next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase

    // Response outputs are registered, so they are prepared for the cycle entering DONE.
    ready_d  = (next_state == DONE);
    slverr_d = ready_d && err;
    rdata_d  = (ready_d && !PWRITE && !err) ? mem[idx] : '0;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      b_rdata <= '0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      PREADY  <= ready_d;
      PSLVERR <= slverr_d;
      PRDATA  <= rdata_d;
      if (b_en) b_rdata <= mem[b_addr];
    end
  end

  // Memory contents survive reset; only the enabled byte lanes are updated.
  always_ff @(posedge PCLK) begin
    if (do_write) begin
      for (int i = 0; i < BYTES; i++) begin
        if (PSTRB[i]) mem[idx][i*8 +: 8] <= PWDATA[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: a transfer-level model checked every cycle, plus
// hand-computed expectations for the main scenarios and a zero-wait-state instance.
module tb_apb4_mem_slave;

  localparam int WS = 2;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata, b_rdata;
  logic [3:0]  pstrb, b_addr;
  logic [2:0]  pprot;
  logic        pready, pslverr, b_en;

  logic        p0_sel, p0_en, p0_write, p0_ready, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata, p0_brdata;
  logic [3:0]  p0_strb;
  logic        p0_ben;
  logic [3:0]  p0_baddr;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [16];
  int          phase = 0;
  logic [31:0] exp_b = '0;

  always #5 PCLK = ~PCLK;

  apb4_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(WS)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PREADY(pready),
    .PRDATA(prdata), .PSLVERR(pslverr), .b_en(b_en), .b_addr(b_addr), .b_rdata(b_rdata)
  );

  apb4_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(p0_sel), .PENABLE(p0_en), .PWRITE(p0_write),
    .PADDR(p0_addr), .PWDATA(p0_wdata), .PSTRB(p0_strb), .PPROT(3'b000), .PREADY(p0_ready),
    .PRDATA(p0_rdata), .PSLVERR(p0_err), .b_en(p0_ben), .b_addr(p0_baddr), .b_rdata(p0_brdata)
  );

  function automatic bit expErr(input logic [31:0] a, input logic w, input logic [3:0] s);
    return ((a >> 2) >= 32'd16) || (a[1:0] != 2'b00) || (!w && (s != 4'h0));
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer-level model: the access phase is WS+1 cycles, the last one completes it.
  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      phase = 0;
      exp_b = '0;
    end else begin
      if (b_en) exp_b = model_mem[b_addr];
      if (phase == 0) begin
        if (psel && !penable) phase = 1;
      end else if (!psel) begin
        phase = 0;
      end else if (phase == WS + 1) begin
        if (pwrite && !expErr(paddr, pwrite, pstrb)) begin
          for (int i = 0; i < 4; i++)
            if (pstrb[i]) model_mem[paddr[5:2]][i*8 +: 8] = pwdata[i*8 +: 8];
        end
        phase = 0;
      end else begin
        phase++;
      end
    end
  end

  always @(negedge PCLK) begin : cmp
    logic        er;
    logic        rdy;
    logic [31:0] rd;
    rdy = (phase == WS + 1);
    er  = expErr(paddr, pwrite, pstrb);
    rd  = (rdy && !pwrite && !er) ? model_mem[paddr[5:2]] : 32'h0;
    checkOutput("cycPready", {31'b0, pready}, {31'b0, rdy});
    checkOutput("cycPslverr", {31'b0, pslverr}, {31'b0, rdy && er});
    checkOutput("cycPrdata", prdata, rd);
    checkOutput("cycBrdata", b_rdata, exp_b);
  end

  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [2:0] prot, input bit b_same,
                               output int waits, output logic [31:0] rd, output logic er);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s; pprot = prot;
    @(posedge PCLK); #1;
    penable = 1'b1;
    waits = 0;
    while (!pready && waits < 20) begin
      @(posedge PCLK); #1;
      waits++;
    end
    if (!pready) checkOutput("timeout", {31'b0, pready}, 32'h1);
    rd = prdata;
    er = pslverr;
    if (b_same) begin
      b_en = 1'b1;
      b_addr = a[5:2];
    end
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0; b_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          waits;
    logic [31:0] rd;
    logic        er;

    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; pstrb = 0; pprot = 0;
    b_en = 0; b_addr = 0;
    p0_sel = 0; p0_en = 0; p0_write = 0; p0_addr = 0; p0_wdata = 0; p0_strb = 0;
    p0_ben = 0; p0_baddr = 0;

    repeat (2) @(posedge PCLK);
    #1;
    checkOutput("rstPready", {31'b0, pready}, 32'h0);
    checkOutput("rstPrdata", prdata, 32'h0);
    checkOutput("rstPslverr", {31'b0, pslverr}, 32'h0);
    checkOutput("rstBrdata", b_rdata, 32'h0);
    PRESET = 1'b0;
    @(posedge PCLK); #1;

    applyStimulus(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, waits, rd, er);
    checkOutput("wrWaits", waits, 32'd2);
    checkOutput("wrErr", {31'b0, er}, 32'h0);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 3'b101, 1'b0, waits, rd, er);
    checkOutput("rdWaits", waits, 32'd2);
    checkOutput("rdData", rd, 32'hDEADBEEF);
    checkOutput("rdErr", {31'b0, er}, 32'h0);

    applyStimulus(1'b1, 32'h08, 32'h11223344, 4'h5, 3'b010, 1'b0, waits, rd, er);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, waits, rd, er);
    checkOutput("strbData", rd, 32'hDE22BE44);

    applyStimulus(1'b1, 32'h40, 32'hFFFFFFFF, 4'hF, 3'b000, 1'b0, waits, rd, er);
    checkOutput("oorWrErr", {31'b0, er}, 32'h1);
    applyStimulus(1'b0, 32'h09, 32'h0, 4'h0, 3'b000, 1'b0, waits, rd, er);
    checkOutput("misRdErr", {31'b0, er}, 32'h1);
    checkOutput("misRdData", rd, 32'h0);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h1, 3'b000, 1'b0, waits, rd, er);
    checkOutput("strbRdErr", {31'b0, er}, 32'h1);
    checkOutput("strbRdData", rd, 32'h0);
    applyStimulus(1'b1, 32'h0A, 32'h0, 4'hF, 3'b000, 1'b0, waits, rd, er);
    checkOutput("misWrErr", {31'b0, er}, 32'h1);
    applyStimulus(1'b1, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, waits, rd, er);
    checkOutput("noopWrErr", {31'b0, er}, 32'h0);
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, waits, rd, er);
    checkOutput("errUnchanged", rd, 32'hDE22BE44);

    applyStimulus(1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 3'b000, 1'b1, waits, rd, er);
    checkOutput("collideOld", b_rdata, 32'hDE22BE44);
    b_en = 1'b1; b_addr = 4'd2;
    @(posedge PCLK); #1;
    b_en = 1'b0;
    checkOutput("collideNew", b_rdata, 32'hCAFEF00D);
    @(posedge PCLK); #1;
    checkOutput("bHold", b_rdata, 32'hCAFEF00D);

    applyStimulus(1'b1, 32'h0C, 32'h12345678, 4'hF, 3'b000, 1'b0, waits, rd, er);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    pwrite = 1'b0; pstrb = 4'h0;
    applyStimulus(1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 1'b0, waits, rd, er);
    checkOutput("abortData", rd, 32'h12345678);

    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h55555555; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    #1 PRESET = 1'b1;
    #1;
    checkOutput("midRstPready", {31'b0, pready}, 32'h0);
    checkOutput("midRstPrdata", prdata, 32'h0);
    checkOutput("midRstPslverr", {31'b0, pslverr}, 32'h0);
    checkOutput("midRstBrdata", b_rdata, 32'h0);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge PCLK); #1;
      checkOutput("postRstIdle", {31'b0, pready}, 32'h0);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
    @(posedge PCLK); #1;
    applyStimulus(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, waits, rd, er);
    checkOutput("rstNoCommit", rd, 32'hCAFEF00D);

    p0_sel = 1'b1; p0_en = 1'b0; p0_write = 1'b1; p0_addr = 32'h04; p0_wdata = 32'hA5A50F0F; p0_strb = 4'hF;
    @(posedge PCLK); #1;
    p0_en = 1'b1;
    checkOutput("ws0WrReady", {31'b0, p0_ready}, 32'h1);
    checkOutput("ws0WrErr", {31'b0, p0_err}, 32'h0);
    @(posedge PCLK); #1;
    p0_en = 1'b0; p0_write = 1'b0; p0_strb = 4'h0;
    checkOutput("ws0SetupIdle", {31'b0, p0_ready}, 32'h0);
    @(posedge PCLK); #1;
    p0_en = 1'b1;
    checkOutput("ws0RdReady", {31'b0, p0_ready}, 32'h1);
    checkOutput("ws0RdData", p0_rdata, 32'hA5A50F0F);
    @(posedge PCLK); #1;
    p0_sel = 1'b0; p0_en = 1'b0;
    @(posedge PCLK); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
